fetch_ctrl: RTL and testbench

Instruction-fetch controller that drives the IF/ID pipeline register: it owns the PC and sequences requests to a multi-cycle instruction memory. It presents the fetched instruction and PC+2 to IF/ID, and inserts NOPs (16'h0800) whenever no valid instruction is ready. It also generates the one-cycle `flush_out` pulse that IF/ID uses to cull its contents after a taken branch or jump.

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_pc_reg.sv | 40 ++++
 rtl/fetch_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: NOP encoding,
// reset PC, PC step and the fetch FSM state encoding.
package fetch_ctrl_pkg;

    localparam logic [15:0] NOP_INSTR_C = 16'h0800;
    localparam logic [15:0] PC_RESET_C  = 16'h0000;
    localparam logic [15:0] PC_STEP_C   = 16'd2;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// 16-bit program counter: synchronous reset, load of a redirect target,
// increment by one instruction (2 bytes, modulo 2^16) or hold.
module fetch_pc_reg
    import fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] PC_RESET = PC_RESET_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        inc,
    output logic [15:0] pc
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    // Next PC: a load outranks an increment; otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + PC_STEP_C;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller feeding the IF/ID register. Owns the PC,
// issues single-beat requests to a multi-cycle instruction memory, buffers
// one word across decode stalls, drops the response of a request that was
// overtaken by a redirect and emits NOPs whenever nothing valid is ready.
// Optional build macro FETCH_ALIGN_CHK_EN adds err_out: an odd PC at issue
// time suppresses the request, raises err_out and halts the fetch unit.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] PC_RESET  = PC_RESET_C,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    input  logic        halt_in,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        imem_stall,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
`ifdef FETCH_ALIGN_CHK_EN
    output logic        err_out,
`endif
    output logic        flush_out
);

    fetch_state_e state_q, state_d;

    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] addr_q, addr_d;
    logic        flush_q, flush_d;
    logic        discard_q, discard_d;

    logic [15:0] pc;
    logic        pc_load;
    logic        pc_inc;

    logic        issue;
    logic        align_err;
    logic        resp_valid;
    logic        resp_drop;
    logic        complete;

    fetch_pc_reg #(
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (redirect_pc),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // A redirect or halt in the FETCH cycle cancels the would-be request so
    // that no wrong-path fetch is ever started.
`ifdef FETCH_ALIGN_CHK_EN
    assign align_err = (state_q == ST_FETCH) && !imem_stall && !redirect
                       && !halt_in && pc[0];
`else
    assign align_err = 1'b0;
`endif

    // Request issue and response classification.
    always_comb begin
        issue      = (state_q == ST_FETCH) && !imem_stall && !redirect
                     && !halt_in && !align_err && !rst;
        resp_valid = issue ? imem_done : ((state_q == ST_WAIT) && imem_done);
        resp_drop  = resp_valid && discard_q;
        complete   = resp_valid && !discard_q;
    end

    assign imem_en   = issue;
    // Outside FETCH the address comes from the latch taken at issue, so it
    // stays stable even when a redirect has already moved the PC.
    assign imem_addr = (state_q == ST_FETCH) ? pc : addr_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (state_q != ST_HALTED) begin
            if (redirect) begin
                // Stay in WAIT only to swallow a still-outstanding response.
                state_d = ((state_q == ST_WAIT) && !imem_done) ? ST_WAIT : ST_FETCH;
            end else if (halt_in || align_err) begin
                state_d = ST_HALTED;
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        if (issue) begin
                            if (!complete) begin
                                state_d = ST_WAIT;
                            end else if (stall) begin
                                state_d = ST_HOLD;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (resp_drop) begin
                            state_d = ST_FETCH;
                        end else if (complete) begin
                            state_d = stall ? ST_HOLD : ST_FETCH;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            state_d = ST_FETCH;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // FSM outputs: IF/ID register values, buffer, discard flag, PC control.
    always_comb begin
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        flush_d   = 1'b0;
        buf_d     = buf_q;
        discard_d = discard_q;
        addr_d    = issue ? pc : addr_q;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        if (state_q == ST_HALTED) begin
            instr_d = NOP_INSTR;
        end else if (redirect) begin
            pc_load   = 1'b1;
            instr_d   = NOP_INSTR;
            flush_d   = 1'b1;
            discard_d = (state_q == ST_WAIT) && !imem_done;
        end else if (halt_in || align_err) begin
            instr_d   = NOP_INSTR;
            discard_d = 1'b0;
        end else if (state_q == ST_HOLD) begin
            if (!stall) begin
                instr_d  = buf_q;
                pc_out_d = pc + PC_STEP_C;
                pc_inc   = 1'b1;
            end
        end else if (complete) begin
            if (!stall) begin
                instr_d  = imem_rdata;
                pc_out_d = pc + PC_STEP_C;
                pc_inc   = 1'b1;
            end else begin
                buf_d = imem_rdata;
            end
        end else begin
            if (resp_drop) begin
                discard_d = 1'b0;
            end
            if (!stall) begin
                instr_d = NOP_INSTR;
            end
        end
    end

    // Datapath and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= NOP_INSTR;
            pc_out_q  <= 16'h0000;
            flush_q   <= 1'b0;
            buf_q     <= 16'h0000;
            discard_q <= 1'b0;
            addr_q    <= PC_RESET;
        end else begin
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            flush_q   <= flush_d;
            buf_q     <= buf_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
        end
    end

    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
    assign flush_out = flush_q;

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q, err_d;

    // Sticky misalignment error, cleared only by reset.
    always_comb begin
        err_d = err_q | align_err;
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a table of per-cycle vectors (inputs,
// expected request outputs in that cycle, expected IF/ID outputs after the
// edge), followed by hand-written reset-mid-request and alignment sequences.
module tb_fetch_ctrl;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        halt_in;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        imem_stall;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic        flush_out;
`ifdef FETCH_ALIGN_CHK_EN
    logic        err_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .halt_in     (halt_in),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_done   (imem_done),
        .imem_stall  (imem_stall),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
`ifdef FETCH_ALIGN_CHK_EN
        .err_out     (err_out),
`endif
        .flush_out   (flush_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redirect;
        logic [15:0] rpc;
        logic        stall;
        logic        halt;
        logic        done;
        logic [15:0] rdata;
        logic        istall;
        logic        exp_en;
        logic        addr_chk;
        logic [15:0] exp_addr;
        logic [15:0] exp_instr;
        logic [15:0] exp_pc;
        logic        exp_flush;
        logic        exp_err;
    } vec_t;

    function automatic vec_t v(input logic r, input logic rd, input logic [15:0] rpc,
                               input logic st, input logic h, input logic dn,
                               input logic [15:0] rdat, input logic ist,
                               input logic en, input logic achk, input logic [15:0] addr,
                               input logic [15:0] ins, input logic [15:0] pco,
                               input logic fl, input logic er);
        vec_t x;
        x.rst = r; x.redirect = rd; x.rpc = rpc; x.stall = st; x.halt = h;
        x.done = dn; x.rdata = rdat; x.istall = ist;
        x.exp_en = en; x.addr_chk = achk; x.exp_addr = addr;
        x.exp_instr = ins; x.exp_pc = pco; x.exp_flush = fl; x.exp_err = er;
        return x;
    endfunction

    task automatic chk(input string tag, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", tag, idx, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check request outputs mid-cycle,
    // check registered outputs just after the rising edge.
    task automatic run(input vec_t x, input int idx);
        @(negedge clk);
        rst = x.rst; redirect = x.redirect; redirect_pc = x.rpc; stall = x.stall;
        halt_in = x.halt; imem_done = x.done; imem_rdata = x.rdata; imem_stall = x.istall;
        #1;
        chk("imem_en", idx, {15'd0, imem_en}, {15'd0, x.exp_en});
        if (x.addr_chk) chk("imem_addr", idx, imem_addr, x.exp_addr);
        @(posedge clk);
        #1;
        chk("instr_out", idx, instr_out, x.exp_instr);
        chk("pc_out", idx, pc_out, x.exp_pc);
        chk("flush_out", idx, {15'd0, flush_out}, {15'd0, x.exp_flush});
`ifdef FETCH_ALIGN_CHK_EN
        chk("err_out", idx, {15'd0, err_out}, {15'd0, x.exp_err});
`endif
        $display("step %0d: en=%b addr=%h instr=%h pc_out=%h flush=%b",
                 idx, imem_en, imem_addr, instr_out, pc_out, flush_out);
    endtask

    vec_t vecs[35];

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; halt_in = 1'b0;
        imem_done = 1'b0; imem_rdata = '0; imem_stall = 1'b0;

        //            rst rd rpc     st h  dn rdata    ist en ac addr     instr    pc_out   fl er
        vecs[0]  = v(1, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    NOP,     16'h0,   0, 0);
        vecs[1]  = v(1, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 1, 16'h0,    NOP,     16'h0,   0, 0);
        // back-to-back hits
        vecs[2]  = v(0, 0, 16'h0, 0, 0, 1, 16'hA000, 0, 1, 1, 16'h0000, 16'hA000, 16'h0002, 0, 0);
        vecs[3]  = v(0, 0, 16'h0, 0, 0, 1, 16'hA002, 0, 1, 1, 16'h0002, 16'hA002, 16'h0004, 0, 0);
        vecs[4]  = v(0, 0, 16'h0, 0, 0, 1, 16'hA004, 0, 1, 1, 16'h0004, 16'hA004, 16'h0006, 0, 0);
        // redirect to 0x10, then a 3-cycle miss
        vecs[5]  = v(0, 1, 16'h0010, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0006, NOP,     16'h0006, 1, 0);
        vecs[6]  = v(0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 1, 1, 16'h0010, NOP,     16'h0006, 0, 0);
        vecs[7]  = v(0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 1, 16'h0010, NOP,     16'h0006, 0, 0);
        vecs[8]  = v(0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 1, 16'h0010, NOP,     16'h0006, 0, 0);
        vecs[9]  = v(0, 0, 16'h0, 0, 0, 1, 16'hB010, 0, 0, 1, 16'h0010, 16'hB010, 16'h0012, 0, 0);
        // redirect while a miss is outstanding; late response dropped
        vecs[10] = v(0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 1, 1, 16'h0012, NOP,     16'h0012, 0, 0);
        vecs[11] = v(0, 1, 16'h0100, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0012, NOP,     16'h0012, 1, 0);
        vecs[12] = v(0, 0, 16'h0, 0, 0, 1, 16'hDEAD, 0, 0, 1, 16'h0012, NOP,     16'h0012, 0, 0);
        vecs[13] = v(0, 0, 16'h0, 0, 0, 1, 16'hC100, 0, 1, 1, 16'h0100, 16'hC100, 16'h0102, 0, 0);
        // two-cycle stall across a hit
        vecs[14] = v(0, 0, 16'h0, 1, 0, 1, 16'hC102, 0, 1, 1, 16'h0102, 16'hC100, 16'h0102, 0, 0);
        vecs[15] = v(0, 0, 16'h0, 1, 0, 0, 16'h0,    0, 0, 1, 16'h0102, 16'hC100, 16'h0102, 0, 0);
        vecs[16] = v(0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 1, 16'h0102, 16'hC102, 16'h0104, 0, 0);
        vecs[17] = v(0, 0, 16'h0, 0, 0, 1, 16'hC104, 0, 1, 1, 16'h0104, 16'hC104, 16'h0106, 0, 0);
        // halt together with redirect: redirect wins
        vecs[18] = v(0, 1, 16'h0200, 0, 1, 1, 16'hEEEE, 0, 0, 1, 16'h0106, NOP,  16'h0106, 1, 0);
        vecs[19] = v(0, 0, 16'h0, 0, 0, 1, 16'hC200, 0, 1, 1, 16'h0200, 16'hC200, 16'h0202, 0, 0);
        // memory busy, with and without decode stall
        vecs[20] = v(0, 0, 16'h0, 1, 0, 0, 16'h0,    1, 0, 1, 16'h0202, 16'hC200, 16'h0202, 0, 0);
        vecs[21] = v(0, 0, 16'h0, 0, 0, 0, 16'h0,    1, 0, 1, 16'h0202, NOP,     16'h0202, 0, 0);
        // halt alone: no further requests, redirect ignored
        vecs[22] = v(0, 0, 16'h0, 0, 1, 0, 16'h0,    0, 0, 1, 16'h0202, NOP,     16'h0202, 0, 0);
        vecs[23] = v(0, 1, 16'h0300, 0, 0, 1, 16'h1234, 0, 0, 0, 16'h0, NOP,     16'h0202, 0, 0);
        vecs[24] = v(0, 0, 16'h0, 0, 0, 1, 16'h5678, 0, 0, 0, 16'h0,    NOP,     16'h0202, 0, 0);
        vecs[25] = v(1, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    NOP,     16'h0000, 0, 0);
        vecs[26] = v(0, 0, 16'h0, 0, 0, 1, 16'hA000, 0, 1, 1, 16'h0000, 16'hA000, 16'h0002, 0, 0);
        // PC wrap at 0xFFFE
        vecs[27] = v(0, 1, 16'hFFFE, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0002, NOP,     16'h0002, 1, 0);
        vecs[28] = v(0, 0, 16'h0, 0, 0, 1, 16'hF00E, 0, 1, 1, 16'hFFFE, 16'hF00E, 16'h0000, 0, 0);
        vecs[29] = v(0, 0, 16'h0, 0, 0, 1, 16'hA000, 0, 1, 1, 16'h0000, 16'hA000, 16'h0002, 0, 0);
        // two redirects during one miss: latest target, one drop
        vecs[30] = v(0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 1, 1, 16'h0002, NOP,     16'h0002, 0, 0);
        vecs[31] = v(0, 1, 16'h0400, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0002, NOP,     16'h0002, 1, 0);
        vecs[32] = v(0, 1, 16'h0500, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0002, NOP,     16'h0002, 1, 0);
        vecs[33] = v(0, 0, 16'h0, 0, 0, 1, 16'hDEAD, 0, 0, 1, 16'h0002, NOP,     16'h0002, 0, 0);
        vecs[34] = v(0, 0, 16'h0, 0, 0, 1, 16'hC500, 0, 1, 1, 16'h0500, 16'hC500, 16'h0502, 0, 0);

        for (int i = 0; i < 35; i++) begin
            run(vecs[i], i);
        end

        // reset while a miss is outstanding: the response is ignored
        run(v(0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 1, 1, 16'h0502, NOP,     16'h0502, 0, 0), 100);
        run(v(1, 0, 16'h0, 0, 0, 1, 16'hBAD1, 0, 0, 0, 16'h0,    NOP,     16'h0000, 0, 0), 101);
        run(v(0, 0, 16'h0, 0, 0, 1, 16'h1111, 0, 1, 1, 16'h0000, 16'h1111, 16'h0002, 0, 0), 102);

`ifdef FETCH_ALIGN_CHK_EN
        // odd redirect target: error, no request, halted
        run(v(0, 1, 16'h0101, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0002, NOP, 16'h0002, 1, 0), 200);
        run(v(0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 1, 16'h0101, NOP, 16'h0002, 0, 1), 201);
        run(v(0, 0, 16'h0, 0, 0, 1, 16'h2222, 0, 0, 0, 16'h0,    NOP, 16'h0002, 0, 1), 202);
        run(v(0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    NOP, 16'h0002, 0, 1), 203);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
